// File: rtl/alu_pwr_sequencer.sv
// ALU power-domain sequencer: requests are registered, then off = quiesce/save/isolate/switch-off and on = switch-on/restore/de-isolate.
// Optional macro PWR_IDLE_TIMEOUT_EN bounds the quiesce wait; outputs are registered from next state (no backpressure).
module alu_pwr_sequencer #(
  parameter int ISO_SETUP    = 2,
  parameter int PWR_UP_CYC   = 4,
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       alu_busy,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       sleep_ack,
  output logic       wake_ack,
  output logic       seq_busy,
  output logic [2:0] pwr_state,
  output logic       sleep_err
);

  typedef enum logic [2:0] {
    ST_ON        = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_SAVE      = 3'd2,
    ST_ISO       = 3'd3,
    ST_OFF       = 3'd4,
    ST_PWRUP     = 3'd5,
    ST_RESTORE   = 3'd6,
    ST_DEISO     = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] ISO_LD  = CNT_W'(ISO_SETUP);
  localparam logic [CNT_W-1:0] PWR_LD  = CNT_W'(PWR_UP_CYC);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             sleep_q, wake_q;
  logic             pwr_en_q, iso_q, save_q, restore_q;
  logic             sack_q, wack_q, busy_q;
`ifdef PWR_IDLE_TIMEOUT_EN
  logic             err_d, err_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
`ifdef PWR_IDLE_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    // A wake seen mid power-down is remembered and replayed once OFF is reached.
    if (wake_q && (state_q inside {ST_WAIT_IDLE, ST_SAVE, ST_ISO}))
      pend_d = 1'b1;
    case (state_q)
      ST_ON: begin
        if (sleep_q) begin
          state_d = ST_WAIT_IDLE;
          cnt_d   = IDLE_LD;
        end
      end
      ST_WAIT_IDLE: begin
        if (!alu_busy) begin
          state_d = ST_SAVE;
        end
`ifdef PWR_IDLE_TIMEOUT_EN
        else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_ON;
          err_d   = 1'b1;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      ST_SAVE: begin
        state_d = ST_ISO;
        cnt_d   = ISO_LD;
      end
      ST_ISO: begin
        if (cnt_q <= CNT_W'(1)) state_d = ST_OFF;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      ST_OFF: begin
        if (wake_q || pend_q) begin
          state_d = ST_PWRUP;
          cnt_d   = PWR_LD;
          pend_d  = 1'b0;
        end
      end
      ST_PWRUP: begin
        if (cnt_q <= CNT_W'(1)) state_d = ST_RESTORE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      ST_RESTORE: state_d = ST_DEISO;
      ST_DEISO:   state_d = ST_ON;
      default:    state_d = ST_ON;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ON;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      sleep_q   <= 1'b0;
      wake_q    <= 1'b0;
      pwr_en_q  <= 1'b1;
      iso_q     <= 1'b0;
      save_q    <= 1'b0;
      restore_q <= 1'b0;
      sack_q    <= 1'b0;
      wack_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      sleep_q   <= sleep_req;
      wake_q    <= wake_req;
      pwr_en_q  <= (state_d != ST_OFF);
      iso_q     <= (state_d inside {ST_ISO, ST_OFF, ST_PWRUP, ST_RESTORE, ST_DEISO});
      save_q    <= (state_d == ST_SAVE);
      restore_q <= (state_d == ST_RESTORE);
      sack_q    <= (state_d == ST_OFF) && (state_q != ST_OFF);
      wack_q    <= (state_d == ST_ON) && (state_q == ST_DEISO);
      busy_q    <= !((state_d == ST_ON) || (state_d == ST_OFF));
    end
  end

`ifdef PWR_IDLE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign sleep_err = err_q;
`else
  assign sleep_err = 1'b0;
`endif

  assign alu_pwr_en = pwr_en_q;
  assign iso_en     = iso_q;
  assign save       = save_q;
  assign restore    = restore_q;
  assign sleep_ack  = sack_q;
  assign wake_ack   = wack_q;
  assign seq_busy   = busy_q;
  assign pwr_state  = state_q;

endmodule

// File: tb/tb_alu_pwr_sequencer.sv
// Bench for alu_pwr_sequencer: a timeline-queue reference model pushes the expected output vector each edge,
// and an independent monitor pops and compares it against the DUT outputs one time unit later.
module tb_alu_pwr_sequencer;
  localparam int ISO = 2;
  localparam int PWR = 4;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sleep_req = 1'b0, wake_req = 1'b0, alu_busy = 1'b0;
  logic       alu_pwr_en, iso_en, save, restore, sleep_ack, wake_ack, seq_busy, sleep_err;
  logic [2:0] pwr_state;

  alu_pwr_sequencer #(.ISO_SETUP(ISO), .PWR_UP_CYC(PWR), .IDLE_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sleep_req(sleep_req), .wake_req(wake_req), .alu_busy(alu_busy),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .save(save), .restore(restore),
    .sleep_ack(sleep_ack), .wake_ack(wake_ack), .seq_busy(seq_busy),
    .pwr_state(pwr_state), .sleep_err(sleep_err)
  );

  always #5 clk = ~clk;

  typedef logic [10:0] vec_t;
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;

  // Vector order: pwr_en, iso, save, restore, sleep_ack, wake_ack, seq_busy, state[2:0], sleep_err
  function automatic vec_t make_vec(int prev, int cur, bit err);
    make_vec = {cur != 4, cur inside {3, 4, 5, 6, 7}, cur == 2, cur == 6,
                (cur == 4) && (prev != 4), (cur == 0) && (prev == 7),
                !((cur == 0) || (cur == 4)), 3'(cur), err};
  endfunction

  // Reference model: a sequence, once committed, is a fixed list of upcoming states.
  int m_state, m_prev, m_next, waited;
  int sched[$];
  bit m_pend, sl_d, wk_d, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_pend = 0; sl_d = 0; wk_d = 0; waited = 0;
      sched.delete();
      exp_q.delete();
    end else begin
      cycle++;
      m_prev = m_state; m_next = m_state; m_err = 0;
      if (wk_d && (m_prev inside {1, 2, 3})) m_pend = 1;
      if (sched.size() > 0) begin
        m_next = sched.pop_front();
      end else begin
        case (m_prev)
          0: if (sl_d) begin m_next = 1; waited = 0; end
          1: begin
            if (!alu_busy) begin
              m_next = 2;
              for (int i = 0; i < ISO; i++) sched.push_back(3);
              sched.push_back(4);
            end
`ifdef PWR_IDLE_TIMEOUT_EN
            else begin
              waited++;
              if (waited == TO) begin m_next = 0; m_err = 1; m_pend = 0; end
            end
`endif
          end
          4: if (m_pend || wk_d) begin
            m_next = 5; m_pend = 0;
            for (int i = 1; i < PWR; i++) sched.push_back(5);
            sched.push_back(6); sched.push_back(7); sched.push_back(0);
          end
          default: ;
        endcase
      end
      m_state = m_next;
      exp_q.push_back(make_vec(m_prev, m_next, m_err));
      sl_d = sleep_req; wk_d = wake_req;
    end
  end

  vec_t act_v, exp_v;
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {alu_pwr_en, iso_en, save, restore, sleep_ack, wake_ack, seq_busy, pwr_state, sleep_err};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got %b expected %b", cycle, act_v, exp_v);
      end
      n_tests++;
      if (save && restore) begin
        n_fail++;
        $display("FAIL save_restore_overlap cycle %0d: got save=%b restore=%b expected not both", cycle, save, restore);
      end
    end
  end

  task automatic cyc(input bit s, input bit w, input bit b);
    sleep_req = s; wake_req = w; alu_busy = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse_check();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({alu_pwr_en, iso_en, save, restore, sleep_ack, wake_ack, seq_busy, pwr_state, sleep_err}
        !== 11'b1_0_0_0_0_0_0_000_0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b",
               {alu_pwr_en, iso_en, save, restore, sleep_ack, wake_ack, seq_busy, pwr_state, sleep_err},
               11'b1_0_0_0_0_0_0_000_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int  run_left;
  bit  busy_r;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    // Plain sleep then wake
    cyc(1'b1, 1'b0, 1'b0); idle(10);
    cyc(1'b0, 1'b1, 1'b0); idle(10);
    // Busy stall in WAIT_IDLE
    cyc(1'b1, 1'b0, 1'b1); repeat (6) cyc(1'b0, 1'b0, 1'b1); idle(10);
    cyc(1'b0, 1'b1, 1'b0); idle(10);
    // Wake arriving while isolating
    cyc(1'b1, 1'b0, 1'b0); idle(2); cyc(1'b0, 1'b1, 1'b0); idle(14);
    // Simultaneous requests in ON: sleep wins
    cyc(1'b1, 1'b1, 1'b0); idle(10);
    // Sleep ignored in OFF and during power-up
    cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0); idle(12);
    // Async reset mid power-up
    cyc(1'b1, 1'b0, 1'b0); idle(8); cyc(1'b0, 1'b1, 1'b0); idle(2);
    reset_pulse_check();
    idle(5);
`ifdef PWR_IDLE_TIMEOUT_EN
    cyc(1'b1, 1'b0, 1'b1); repeat (22) cyc(1'b0, 1'b0, 1'b1); idle(5);
    cyc(1'b1, 1'b0, 1'b1); repeat (3) cyc(1'b0, 1'b1, 1'b1); repeat (16) cyc(1'b0, 1'b0, 1'b1); idle(5);
`endif
    run_left = 0; busy_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        busy_r   = ($urandom_range(0, 2) == 0);
        run_left = $urandom_range(1, 24);
      end
      run_left--;
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), busy_r);
    end
    idle(40);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
